// File: rtl/uart_buffered.sv
// rtl/uart_buffered.sv - Buffered 8N1 UART with TX/RX FIFOs, sticky errors and level IRQ
//
// uart_fifo: synchronous FIFO, power-of-two DEPTH, pointers one bit wider than the index.
//   clk, rst          : clock, synchronous active-high reset (pointers only)
//   push, wdata       : write side; dropped when full unless a pop happens the same cycle
//   pop, rdata        : read side; rdata is the head entry (combinational), pop ignored when empty
//   empty, full       : occupancy flags
//
// uart_buffered: memory-mapped UART on the CPU chip-select bus.
//   clk, rst          : clock, synchronous active-high reset
//   cs, we, addr      : bus cycle qualifiers and register offset ($00 DATA, $01 STATUS, $02 CONTROL)
//   data_in           : write data
//   data_out          : registered read data, valid the cycle after the read edge
//   tx, rx            : serial line out (idles high) / serial line in (asynchronous)
//   irq               : registered level interrupt

module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         pop_eff;
  logic         push_eff;

  assign empty    = (wptr == rptr);
  assign full     = ((wptr - rptr) == FULL_CNT);
  assign pop_eff  = pop & ~empty;
  // A pop on a full FIFO frees the slot the push lands in, so both proceed.
  assign push_eff = push & (~full | pop_eff);
  assign rdata    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_eff) wptr <= wptr + 1'b1;
      if (pop_eff)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module uart_buffered #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  input  logic       rx,
  output logic       irq
);
  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int TW      = $clog2(BIT_CYC + 1);
  localparam logic [TW-1:0] T_FULL = TW'(BIT_CYC);
  localparam logic [TW-1:0] T_HALF = TW'(BIT_CYC / 2);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic rd_en, wr_en;
  assign rd_en = cs & ~we;
  assign wr_en = cs & we;

  // TX path
  tx_state_t     tx_state;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_busy_q;
  logic          tx_empty, tx_full, tx_pop, tx_expire, tx_idle;
  logic [7:0]    tx_rdata;

  assign tx_expire = (tx_timer == T_ONE);
  assign tx_pop    = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_expire));
  // tx lags the state by one cycle, so idle is only reported once the stop bit has left the pin.
  assign tx_idle   = tx_empty & (tx_state == TX_IDLE) & ~tx_busy_q;

  uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en & (addr == 8'h00)),
    .wdata (data_in),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .full  (tx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_timer  <= T_ZERO;
      tx_idx    <= 3'd0;
      tx_shift  <= 8'h00;
      tx_busy_q <= 1'b0;
      tx        <= 1'b1;
    end else begin
      tx_busy_q <= (tx_state != TX_IDLE);
      if (tx_timer != T_ZERO) tx_timer <= tx_timer - T_ONE;
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_rdata;
            tx_timer <= T_FULL;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx <= 1'b0;
          if (tx_expire) begin
            tx_timer <= T_FULL;
            tx_idx   <= 3'd0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx <= tx_shift[0];
          if (tx_expire) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_timer <= T_FULL;
            if (tx_idx == 3'd7) tx_state <= TX_STOP;
            else                tx_idx   <= tx_idx + 3'd1;
          end
        end
        TX_STOP: begin
          tx <= 1'b1;
          if (tx_expire) begin
            // Chain straight into the next frame so back-to-back bytes have no idle gap.
            if (!tx_empty) begin
              tx_shift <= tx_rdata;
              tx_timer <= T_FULL;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX path
  rx_state_t     rx_state;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_meta, rx_sync, rx_prev;
  logic          rx_fall, rx_expire, rx_stop_edge, rx_push;
  logic          rx_empty, rx_full;
  logic [7:0]    rx_rdata;

  assign rx_fall      = rx_prev & ~rx_sync;
  assign rx_expire    = (rx_timer == T_ONE);
  assign rx_stop_edge = (rx_state == RX_STOP) & rx_expire;
  assign rx_push      = rx_stop_edge & rx_sync & ~rx_full;

  uart_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rd_en & (addr == 8'h00)),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_timer <= T_ZERO;
      rx_idx   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      if (rx_timer != T_ZERO) rx_timer <= rx_timer - T_ONE;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_timer <= T_HALF;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_expire) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_timer <= T_FULL;
              rx_idx   <= 3'd0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_expire) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_timer <= T_FULL;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_expire) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Registers, read mux and interrupt
  logic       rx_ovr, rx_fe, rxie, txie;
  logic       status_w1c;
  logic [7:0] status;

  assign status_w1c = wr_en & (addr == 8'h01);
  assign status = {2'b00, tx_full, rx_fe, rx_ovr, tx_idle, ~rx_empty, ~tx_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr   <= 1'b0;
      rx_fe    <= 1'b0;
      rxie     <= 1'b0;
      txie     <= 1'b0;
      data_out <= 8'h00;
      irq      <= 1'b0;
    end else begin
      // Set terms are OR'd last so a new error wins over a same-cycle clear.
      rx_ovr <= (rx_ovr & ~(status_w1c & data_in[3])) | (rx_stop_edge & rx_sync & rx_full);
      rx_fe  <= (rx_fe  & ~(status_w1c & data_in[4])) | (rx_stop_edge & ~rx_sync);
      if (wr_en && addr == 8'h02) begin
        rxie <= data_in[0];
        txie <= data_in[1];
      end
      if (rd_en) begin
        case (addr)
          8'h00:   data_out <= rx_empty ? 8'h00 : rx_rdata;
          8'h01:   data_out <= status;
          8'h02:   data_out <= {6'b000000, txie, rxie};
          default: data_out <= 8'h00;
        endcase
      end
      irq <= (rxie & ~rx_empty) | (txie & tx_empty);
    end
  end
endmodule

// File: tb/tb_uart_buffered.sv
// tb/tb_uart_buffered.sv - Scoreboard bench for uart_buffered (BIT_CYC = 10, depth 4)
//
// Drives the register bus and the rx line from one stimulus process; expected read data and
// expected transmitted bytes go into queues that independent monitors drain and compare.

module tb_uart_buffered;
  localparam int BIT = 10;

  logic       clk = 1'b0;
  logic       rst, cs, we, rx, tx, irq;
  logic [7:0] addr, data_in, data_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] exp_rd_q[$];
  string      exp_nm_q[$];
  logic [7:0] exp_tx_q[$];
  int         tx_start_q[$];

  uart_buffered #(
    .CLK_FREQ  (1000000),
    .BAUD_RATE (100000),
    .TX_DEPTH  (4),
    .RX_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .rx       (rx),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Positions the next bus cycle so that it is sampled on edge e.
  task automatic wait_edge(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    exp_rd_q.push_back(e);
    exp_nm_q.push_back(nm);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    idle(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    line(stop_bit, BIT);
  endtask

  // Read monitor: every sampled read is compared the cycle after its edge.
  initial begin
    forever begin
      @(posedge clk);
      if (cs === 1'b1 && we === 1'b0 && rst === 1'b0) begin
        @(negedge clk);
        if (exp_rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got %0h, expected no read", data_out);
        end else begin
          check(exp_nm_q.pop_front(), int'(data_out), int'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // TX monitor: decodes frames at mid-bit and compares against the expected byte queue.
  initial begin
    logic [7:0] b;
    int         st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        st = cyc;
        repeat (BIT / 2) @(negedge clk);
        check("tx_start_bit", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        check("tx_stop_bit", int'(tx), 1);
        tx_start_q.push_back(st);
        if (exp_tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got %0h, expected no frame", b);
        end else begin
          check("tx_byte", int'(b), int'(exp_tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_tx", int'(tx), 1);
    check("reset_irq", int'(irq), 0);
    rd(8'h01, 8'h05, "reset_status");
    rd(8'h02, 8'h00, "reset_control");
    idle(2);

    // Back-to-back TX
    tx_start_q.delete();
    exp_tx_q.push_back(8'h55);
    exp_tx_q.push_back(8'hA3);
    wr(8'h00, 8'h55);
    t0 = cyc;
    wr(8'h00, 8'hA3);
    wait_edge(t0 + 50);
    rd(8'h01, 8'h01, "b2b_status_mid");
    wait_edge(t0 + 201);
    rd(8'h01, 8'h01, "b2b_status_last_stop");
    wait_edge(t0 + 203);
    rd(8'h01, 8'h05, "b2b_status_idle");
    check("b2b_frame_count", tx_start_q.size(), 2);
    if (tx_start_q.size() >= 2) begin
      check("b2b_first_fall", tx_start_q[0], t0 + 2);
      check("b2b_second_fall", tx_start_q[1], t0 + 102);
    end
    idle(5);

    // TX overflow
    for (int i = 1; i <= 5; i++) exp_tx_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(8'h00, 8'(i));
    rd(8'h01, 8'h20, "ovf_status_full");
    idle(700);
    check("ovf_tx_remaining", exp_tx_q.size(), 0);

    // RX basic
    wr(8'h02, 8'h01);
    idle(2);
    check("rxb_irq_before", int'(irq), 0);
    send_frame(8'h3C, 1'b1);
    check("rxb_irq_after", int'(irq), 1);
    rd(8'h00, 8'h3C, "rxb_data");
    rd(8'h01, 8'h05, "rxb_status_after");
    check("rxb_irq_cleared", int'(irq), 0);
    rd(8'h00, 8'h00, "rxb_empty_read");

    // RX overrun
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    rd(8'h01, 8'h0F, "ovr_status");
    for (int i = 0; i < 4; i++) rd(8'h00, 8'h10 + 8'(i), "ovr_data");
    rd(8'h00, 8'h00, "ovr_empty_read");
    wr(8'h01, 8'h08);
    rd(8'h01, 8'h05, "ovr_cleared");

    // RX errors
    line(1'b0, 3);
    line(1'b1, 30);
    rd(8'h01, 8'h05, "err_glitch_status");
    send_frame(8'hA5, 1'b0);
    line(1'b1, BIT);
    send_frame(8'h5A, 1'b1);
    rd(8'h01, 8'h17, "err_fe_status");
    rd(8'h00, 8'h5A, "err_next_data");
    rd(8'h00, 8'h00, "err_no_extra");
    rd(8'h01, 8'h15, "err_fe_sticky");
    wr(8'h01, 8'h10);
    rd(8'h01, 8'h05, "err_fe_cleared");
    rd(8'h02, 8'h01, "control_readback");
    idle(3);

    check("rd_remaining", exp_rd_q.size(), 0);
    check("tx_remaining", exp_tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_buffered.md
# uart_buffered

Buffered, parametrised UART peripheral replacing the TX-only UART in the CPU's $C0xx I/O region. It adds a full 8N1 receiver, independent TX and RX FIFOs of configurable depth, sticky error flags, a control register and a level interrupt output. It sits behind the address decoder on the same chip-select bus as the other memory-mapped peripherals.

## Interface
- CLK_FREQ, 25000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate; BIT_CYC = CLK_FREQ/BAUD_RATE (integer, at least 4)
- TX_DEPTH, 16, TX FIFO entries (power of two, at least 2)
- RX_DEPTH, 16, RX FIFO entries (power of two, at least 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cs  in  1  chip select from address decoder
- we  in  1  write enable (1 = write, 0 = read when cs is high)
- addr  in  8  register offset
- data_in  in  8  write data from CPU
- data_out  out  8  registered read data
- tx  out  1  serial output, idles high
- rx  in  1  serial input, asynchronous
- irq  out  1  level interrupt, active high

## Operation
- Register map:
  - $00 DATA: a write pushes to the TX FIFO; the write is silently dropped if the FIFO is full. A read pops the RX FIFO; reading an empty FIFO returns $00 and pops nothing.
  - $01 STATUS: bit0 TX FIFO not full; bit1 RX FIFO not empty; bit2 TX idle (FIFO empty and shifter idle); bit3 RX overrun (sticky); bit4 framing error (sticky); bit5 TX FIFO full; bits 7:6 read 0. Writing 1 to bit3 or bit4 clears that bit; other bits ignore writes.
  - $02 CONTROL: R/W. bit0 RXIE, bit1 TXIE; other bits read 0.
  - Any other offset reads $00; writes to it are ignored.
- irq = (RXIE & RX not empty) | (TXIE & TX FIFO empty). Registered.
- TX state machine: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state/bit lasts exactly BIT_CYC cycles.
  - In IDLE with the FIFO not empty, the FSM pops one byte and enters START.
  - At the end of STOP with the FIFO not empty, it pops and enters START directly, with no idle gap.
- RX input: 2-flop synchroniser, both flops reset to 1.
- RX state machine: IDLE → START → DATA → STOP.
  - IDLE: a synchronised falling edge enters START and loads the timer with BIT_CYC/2.
  - START: at timer expiry, sample; if high (false start) return to IDLE, else reload BIT_CYC.
  - DATA: take 8 samples at BIT_CYC intervals, LSB first.
  - STOP: sample once more at BIT_CYC.
    - Stop bit = 0: set framing error, discard the byte, return to IDLE.
    - Stop bit = 1 and RX FIFO full: set overrun, discard the new byte; stored data is kept.
    - Stop bit = 1 otherwise: push the byte.
  - After STOP the FSM returns to IDLE immediately, so a new start edge is accepted in the next cycle.
- FIFO simultaneous events:
  - Push and pop in the same cycle on a full FIFO: both take effect, and occupancy is unchanged.
  - Push and pop on an empty FIFO: the pop is ignored and the push takes effect.
- Pointer width is log2(DEPTH)+1 bits. Wrap-around uses natural modulo arithmetic.

## Timing
- Reset values: tx = 1, data_out = $00, irq = 0, both FIFOs empty, STATUS/CONTROL flags 0, both FSMs IDLE.
- Reset asserted mid-frame aborts the frame immediately: tx = 1 on the next cycle, and FIFO contents are discarded.
- Read latency:
  - data_out is loaded on the edge where cs & !we is sampled, and is valid the following cycle.
  - data_out holds its value when no read occurs.
  - The RX pop happens on that same edge.
- STATUS read reflects state before the same-edge update. It is not affected by a write in the same cycle.
- TX latency:
  - A DATA write at edge N with TX idle pushes at N. The FSM pops at N+1, and tx goes low at N+2.
  - The frame then lasts 10×BIT_CYC cycles.
- TX idle (bit2) returns to 1 in the cycle after the last stop bit completes.
- RX latency: the byte is visible (bit1 = 1) the cycle after the stop-bit sample edge.
- Sticky flag set and W1C clear in the same cycle: set wins.

## Test plan
Test parameters: CLK_FREQ = 1000000, BAUD_RATE = 100000 (BIT_CYC = 10), TX_DEPTH = RX_DEPTH = 4.
- **Reset:** after reset, tx = 1, irq = 0, and a STATUS read returns $05.
- **Back-to-back TX:** write $55 then $A3 on consecutive cycles.
  - tx falls 2 cycles after the first write edge.
  - Both 100-cycle frames appear LSB-first with no gap between them.
  - STATUS bit2 = 1 only after the second stop bit.
- **TX overflow:** write 6 bytes on consecutive cycles ($01–$06).
  - Exactly $01–$05 are transmitted; $06 is dropped.
  - STATUS bit5 = 1 while the FIFO holds 4 bytes.
- **RX basic:** drive frame $3C on rx with RXIE = 1.
  - irq rises after the stop sample.
  - A DATA read returns $3C; then bit1 = 0 and irq = 0.
  - A second read returns $00.
- **RX overrun:** send 5 frames $10–$14 without reading.
  - bit3 = 1.
  - Reads return $10–$13, then $00.
  - Writing $08 to STATUS clears bit3.
- **RX errors:**
  - A 3-cycle low glitch on rx produces no push and no flags.
  - A frame with stop bit = 0 sets bit4 and pushes nothing.
  - A valid frame immediately following is received correctly.
